// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC sequencing controller.
// Used by mac_seq_ctrl and mac_seq_ctrl_mac.
package mac_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int DRAIN_LEN = 3;

endpackage

// File: rtl/mac_seq_ctrl_mac.sv
// Signed multiply-accumulate: registered operands, then accumulator.
// sload restarts the sum with the current product; zero operands hold it.
module mac_seq_ctrl_mac
  import mac_seq_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int BW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sload,
  input  logic signed [AW-1:0]     a,
  input  logic signed [BW-1:0]     b,
  output logic signed [AW+BW:0]    acc
);

  localparam int PW = AW + BW;

  logic signed [AW-1:0] a_q;
  logic signed [BW-1:0] b_q;
  logic                 sload_q;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   prod_x;

  assign prod   = a_q * b_q;
  assign prod_x = {prod[PW-1], prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sload_q <= 1'b0;
      acc     <= '0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      sload_q <= sload;
      acc     <= sload_q ? prod_x : acc + prod_x;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences memory reads into a MAC and returns a dot product.
// Define MAC_SEQ_CTRL_RELU_EN to clamp negative results to zero.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int WEIGHT_WIDTH  = 16,
  parameter int FEATURE_WIDTH = 16,
  parameter int MEMORY_DEPTH  = 7
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          start_ready,
  input  logic [MEMORY_DEPTH:0]         len,
  input  logic [MEMORY_DEPTH-1:0]       w_base,
  input  logic [MEMORY_DEPTH-1:0]       f_base,
  output logic                          w_rd_en,
  output logic                          f_rd_en,
  output logic [MEMORY_DEPTH-1:0]       w_addr,
  output logic [MEMORY_DEPTH-1:0]       f_addr,
  input  logic signed [WEIGHT_WIDTH-1:0]  w_rdata,
  input  logic signed [FEATURE_WIDTH-1:0] f_rdata,
  output logic signed [FEATURE_WIDTH+WEIGHT_WIDTH:0] result,
  output logic                          result_valid,
  input  logic                          result_ready
);

  localparam int AW = MEMORY_DEPTH;
  localparam int LW = MEMORY_DEPTH + 1;
  localparam int RW = FEATURE_WIDTH + WEIGHT_WIDTH + 1;

  state_e state_q, state_d;

  logic [LW-1:0] len_q, cnt_q;
  logic [AW-1:0] wb_q, fb_q;
  logic          vld_q, first_q;
  logic          rd_en, run_last, drain_last;

  logic signed [RW-1:0]            acc, res_in;
  logic signed [RW-1:0]            result_q;
  logic signed [WEIGHT_WIDTH-1:0]  mac_a;
  logic signed [FEATURE_WIDTH-1:0] mac_b;

  assign rd_en      = (state_q == RUN);
  assign run_last   = (cnt_q == len_q - LW'(1));
  assign drain_last = (cnt_q == LW'(DRAIN_LEN - 1));

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign w_rd_en      = rd_en;
  assign f_rd_en      = rd_en;
  assign w_addr = rd_en ? wb_q + cnt_q[AW-1:0] : '0;
  assign f_addr = rd_en ? fb_q + cnt_q[AW-1:0] : '0;

  // Only data for an issued read reaches the MAC.
  assign mac_a = vld_q ? w_rdata : '0;
  assign mac_b = vld_q ? f_rdata : '0;

`ifdef MAC_SEQ_CTRL_RELU_EN
  assign res_in = acc[RW-1] ? '0 : acc;
`else
  assign res_in = acc;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (run_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_d = DONE;
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      cnt_q    <= '0;
      wb_q     <= '0;
      fb_q     <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      result_q <= '0;
    end else begin
      vld_q   <= rd_en;
      first_q <= rd_en && (cnt_q == '0);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            wb_q  <= w_base;
            fb_q  <= f_base;
            cnt_q <= '0;
            if (len == '0) result_q <= '0;
          end
        end
        RUN: begin
          cnt_q <= run_last ? '0 : cnt_q + LW'(1);
        end
        DRAIN: begin
          cnt_q <= cnt_q + LW'(1);
          if (drain_last) result_q <= res_in;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  mac_seq_ctrl_mac #(
    .AW (WEIGHT_WIDTH),
    .BW (FEATURE_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (~reset_n),
    .sload (first_q),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: memory model plus dot-product reference.
// Honours MAC_SEQ_CTRL_RELU_EN when the design is built with it.
module tb_mac_seq_ctrl;

  localparam int WW    = 16;
  localparam int FW    = 16;
  localparam int MD    = 7;
  localparam int DEPTH = 1 << MD;
  localparam int LW    = MD + 1;
  localparam int RW    = WW + FW + 1;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic                 start_ready;
  logic [LW-1:0]        len;
  logic [MD-1:0]        w_base, f_base;
  logic                 w_rd_en, f_rd_en;
  logic [MD-1:0]        w_addr, f_addr;
  logic signed [WW-1:0] w_rdata;
  logic signed [FW-1:0] f_rdata;
  logic signed [RW-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  logic signed [WW-1:0] wmem [DEPTH];
  logic signed [FW-1:0] fmem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  mac_seq_ctrl #(
    .WEIGHT_WIDTH  (WW),
    .FEATURE_WIDTH (FW),
    .MEMORY_DEPTH  (MD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_ready  (start_ready),
    .len          (len),
    .w_base       (w_base),
    .f_base       (f_base),
    .w_rd_en      (w_rd_en),
    .f_rd_en      (f_rd_en),
    .w_addr       (w_addr),
    .f_addr       (f_addr),
    .w_rdata      (w_rdata),
    .f_rdata      (f_rdata),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; garbage when no read is issued.
  always @(posedge clk) begin
    w_rdata <= w_rd_en ? wmem[w_addr] : WW'($urandom);
    f_rdata <= f_rd_en ? fmem[f_addr] : FW'($urandom);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [RW-1:0] model(int ln, int wb, int fb);
    longint acc;
    logic signed [RW-1:0] r;
    acc = 0;
    for (int k = 0; k < ln; k++) begin
      acc += longint'(wmem[(wb + k) % DEPTH])
           * longint'(fmem[(fb + k) % DEPTH]);
    end
    r = RW'(acc);
`ifdef MAC_SEQ_CTRL_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  task automatic run_job(input int ln, input int wb,
                         input int fb, input int hold);
    logic signed [RW-1:0] exp_res;
    int  k, n;
    bit  seen;
    exp_res = model(ln, wb, fb);
    @(negedge clk);
    chk("start_ready", start_ready, 1);
    start  = 1'b1;
    len    = LW'(ln);
    w_base = MD'(wb);
    f_base = MD'(fb);
    @(negedge clk);
    start  = 1'b0;
    len    = LW'($urandom);
    w_base = MD'($urandom);
    f_base = MD'($urandom);
    k = 0;
    n = 1;
    seen = 1'b0;
    while (n < 400) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (w_rd_en || f_rd_en) begin
        chk("rd_en_pair", f_rd_en, w_rd_en);
        chk("w_addr", w_addr, (wb + k) % DEPTH);
        chk("f_addr", f_addr, (fb + k) % DEPTH);
        k++;
      end
      @(negedge clk);
      n++;
    end
    chk("valid_seen", seen, 1);
    chk("latency", n, (ln == 0) ? 1 : ln + 4);
    chk("reads", k, ln);
    chk("result", result, exp_res);
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom);
      len   = LW'($urandom);
      @(negedge clk);
      chk("hold_valid", result_valid, 1);
      chk("hold_result", result, exp_res);
      chk("hold_rd_en", w_rd_en, 0);
    end
    start        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", start_ready, 1);
    chk("valid_drop", result_valid, 0);
    start        = 1'b0;
    result_ready = 1'b0;
  endtask

  initial begin
    bit any_valid;
    reset_n      = 1'b0;
    start        = 1'b0;
    len          = '0;
    w_base       = '0;
    f_base       = '0;
    result_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wmem[i] = WW'($urandom);
      fmem[i] = FW'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_rd_en", {w_rd_en, f_rd_en}, 0);
    chk("rst_addr", {w_addr, f_addr}, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wmem[i] = WW'(i + 1);
      fmem[i] = FW'(i + 5);
    end
    run_job(4, 0, 0, 0);
`ifdef MAC_SEQ_CTRL_RELU_EN
    chk("dot70", result, 70);
`else
    chk("dot70", result, 70);
`endif

    wmem[10] = -16'sd3;
    fmem[20] = 16'sd7;
    run_job(1, 10, 20, 0);
`ifdef MAC_SEQ_CTRL_RELU_EN
    chk("neg21", result, 0);
`else
    chk("neg21", result, 64'(-33'sd21));
`endif

    run_job(0, 5, 9, 0);
    run_job(3, 126, 0, 0);
    run_job(5, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, DEPTH - 1), 10);
    run_job(6, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, DEPTH - 1), 0);

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wmem[i] = WW'($urandom);
        fmem[i] = FW'($urandom);
      end
      run_job($urandom_range(1, DEPTH),
              $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 3));
    end
    run_job(DEPTH, 100, 3, 1);

    @(negedge clk);
    start  = 1'b1;
    len    = LW'(20);
    w_base = MD'(7);
    f_base = MD'(9);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run", w_rd_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ready", start_ready, 1);
    chk("async_rd_en", {w_rd_en, f_rd_en}, 0);
    chk("async_addr", {w_addr, f_addr}, 0);
    chk("async_valid", result_valid, 0);
    chk("async_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    any_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (result_valid) any_valid = 1'b1;
    end
    chk("abandoned", any_valid, 0);
    run_job(0, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
